// File: rtl/dallanma_cozum_birimi_if.sv
// Branch resolution bus: prediction enqueue, execute resolve,
// predictor training and redirect outputs.
interface dallanma_cozum_birimi_if #(
  parameter int SAYAC_GENIS = 16
);
  logic                   i_ongoru_gecerli;
  logic                   i_ongoru;
  logic [31:0]            i_buyruk_sayaci;
  logic [31:0]            i_ongoru_hedef;
  logic                   o_hazir;
  logic                   i_cozum_gecerli;
  logic                   i_gercek_atladi;
  logic [31:0]            i_gercek_hedef;
  logic                   o_guncelle;
  logic                   o_buyruk_atladi;
  logic                   o_ongoru_yanlis;
  logic [31:0]            o_duzeltme_adresi;
  logic                   o_hata;
  logic [SAYAC_GENIS-1:0] o_dallanma_sayisi;
  logic [SAYAC_GENIS-1:0] o_yanlis_sayisi;

  modport master (
    output i_ongoru_gecerli, i_ongoru, i_buyruk_sayaci,
    output i_ongoru_hedef, i_cozum_gecerli,
    output i_gercek_atladi, i_gercek_hedef,
    input  o_hazir, o_guncelle, o_buyruk_atladi,
    input  o_ongoru_yanlis, o_duzeltme_adresi, o_hata,
    input  o_dallanma_sayisi, o_yanlis_sayisi
  );

  modport slave (
    input  i_ongoru_gecerli, i_ongoru, i_buyruk_sayaci,
    input  i_ongoru_hedef, i_cozum_gecerli,
    input  i_gercek_atladi, i_gercek_hedef,
    output o_hazir, o_guncelle, o_buyruk_atladi,
    output o_ongoru_yanlis, o_duzeltme_adresi, o_hata,
    output o_dallanma_sayisi, o_yanlis_sayisi
  );
endinterface

// File: rtl/dallanma_cozum_birimi.sv
// Branch resolution: in-order prediction FIFO, mispredict
// detection with redirect and flush, saturating statistics.
module dallanma_cozum_birimi #(
  parameter int DERINLIK    = 4,
  parameter int SAYAC_GENIS = 16
) (
  input logic                    i_saat,
  input logic                    i_reset,
  dallanma_cozum_birimi_if.slave bus
);
  localparam int AW = $clog2(DERINLIK);
  localparam int PW = AW + 1;

  typedef enum logic {
    CALISMA  = 1'b0,
    BOSALTMA = 1'b1
  } durum_t;

  durum_t durum_q, durum_d;

  logic [PW-1:0] yaz_q, yaz_d;
  logic [PW-1:0] oku_q, oku_d;
  logic [PW-1:0] sayi;

  logic        ongoru_m [DERINLIK];
  logic [31:0] pc_m     [DERINLIK];
  logic [31:0] hedef_m  [DERINLIK];

  logic        guncelle_q, guncelle_d;
  logic        atladi_q, atladi_d;
  logic        yanlis_q, yanlis_d;
  logic [31:0] duzeltme_q, duzeltme_d;
  logic        hata_q, hata_d;

  logic [SAYAC_GENIS-1:0] dal_q, dal_d;
  logic [SAYAC_GENIS-1:0] yan_q, yan_d;

  logic        dolu, bos, hazir;
  logic        kabul, cozum, yanlis, yaz;
  logic        bas_ongoru;
  logic [31:0] bas_pc, bas_hedef;

  assign sayi  = yaz_q - oku_q;
  assign dolu  = (sayi == PW'(DERINLIK));
  assign bos   = (yaz_q == oku_q);
  assign hazir = (durum_q == CALISMA) && !dolu;

  assign bas_ongoru = ongoru_m[oku_q[AW-1:0]];
  assign bas_pc     = pc_m[oku_q[AW-1:0]];
  assign bas_hedef  = hedef_m[oku_q[AW-1:0]];

  // Next-state: enqueue/resolve decisions, flush and outputs
  always_comb begin
    durum_d    = CALISMA;
    yaz_d      = yaz_q;
    oku_d      = oku_q;
    guncelle_d = 1'b0;
    atladi_d   = atladi_q;
    yanlis_d   = 1'b0;
    duzeltme_d = duzeltme_q;
    hata_d     = hata_q;
    dal_d      = dal_q;
    yan_d      = yan_q;
    kabul      = bus.i_ongoru_gecerli && hazir;
    cozum      = bus.i_cozum_gecerli && (durum_q == CALISMA) && !bos;
    yanlis     = 1'b0;

    if (durum_q == CALISMA) begin
      if (bus.i_ongoru_gecerli && !hazir)
        hata_d = 1'b1;
      if (bus.i_cozum_gecerli && bos)
        hata_d = 1'b1;
    end

    if (cozum) begin
      yanlis = (bas_ongoru != bus.i_gercek_atladi) ||
               (bas_ongoru && bus.i_gercek_atladi &&
                (bas_hedef != bus.i_gercek_hedef));
      guncelle_d = 1'b1;
      atladi_d   = bus.i_gercek_atladi;
      oku_d      = oku_q + PW'(1);
      if (dal_q != '1)
        dal_d = dal_q + SAYAC_GENIS'(1);
    end

    if (kabul)
      yaz_d = yaz_q + PW'(1);

    if (yanlis) begin
      yanlis_d   = 1'b1;
      duzeltme_d = bus.i_gercek_atladi ? bus.i_gercek_hedef
                                       : bas_pc + 32'd4;
      yaz_d      = oku_d;
      durum_d    = BOSALTMA;
      if (yan_q != '1)
        yan_d = yan_q + SAYAC_GENIS'(1);
    end

    yaz = kabul && !yanlis;
  end

  // State, pointer and output registers
  always_ff @(posedge i_saat or posedge i_reset) begin
    if (i_reset) begin
      durum_q    <= CALISMA;
      yaz_q      <= '0;
      oku_q      <= '0;
      guncelle_q <= 1'b0;
      atladi_q   <= 1'b0;
      yanlis_q   <= 1'b0;
      duzeltme_q <= '0;
      hata_q     <= 1'b0;
      dal_q      <= '0;
      yan_q      <= '0;
    end else begin
      durum_q    <= durum_d;
      yaz_q      <= yaz_d;
      oku_q      <= oku_d;
      guncelle_q <= guncelle_d;
      atladi_q   <= atladi_d;
      yanlis_q   <= yanlis_d;
      duzeltme_q <= duzeltme_d;
      hata_q     <= hata_d;
      dal_q      <= dal_d;
      yan_q      <= yan_d;
    end
  end

  // FIFO storage; contents are don't-care outside the pointers
  always_ff @(posedge i_saat) begin
    if (yaz) begin
      ongoru_m[yaz_q[AW-1:0]] <= bus.i_ongoru;
      pc_m[yaz_q[AW-1:0]]     <= bus.i_buyruk_sayaci;
      hedef_m[yaz_q[AW-1:0]]  <= bus.i_ongoru_hedef;
    end
  end

  assign bus.o_hazir           = hazir;
  assign bus.o_guncelle        = guncelle_q;
  assign bus.o_buyruk_atladi   = atladi_q;
  assign bus.o_ongoru_yanlis   = yanlis_q;
  assign bus.o_duzeltme_adresi = duzeltme_q;
  assign bus.o_hata            = hata_q;
  assign bus.o_dallanma_sayisi = dal_q;
  assign bus.o_yanlis_sayisi   = yan_q;
endmodule

// File: tb/tb_dallanma_cozum_birimi.sv
// Directed bench for the branch resolution stage.
// Second instance uses 4-bit counters for saturation.
module tb_dallanma_cozum_birimi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dallanma_cozum_birimi_if #(.SAYAC_GENIS(16)) bus1 ();
  dallanma_cozum_birimi_if #(.SAYAC_GENIS(4))  bus4 ();

  dallanma_cozum_birimi #(
    .DERINLIK(4), .SAYAC_GENIS(16)
  ) dut (
    .i_saat(clk), .i_reset(rst), .bus(bus1.slave)
  );

  dallanma_cozum_birimi #(
    .DERINLIK(4), .SAYAC_GENIS(4)
  ) dut4 (
    .i_saat(clk), .i_reset(rst4), .bus(bus4.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr1();
    bus1.i_ongoru_gecerli = 1'b0;
    bus1.i_ongoru         = 1'b0;
    bus1.i_buyruk_sayaci  = '0;
    bus1.i_ongoru_hedef   = '0;
    bus1.i_cozum_gecerli  = 1'b0;
    bus1.i_gercek_atladi  = 1'b0;
    bus1.i_gercek_hedef   = '0;
  endtask

  task automatic clr4();
    bus4.i_ongoru_gecerli = 1'b0;
    bus4.i_ongoru         = 1'b0;
    bus4.i_buyruk_sayaci  = '0;
    bus4.i_ongoru_hedef   = '0;
    bus4.i_cozum_gecerli  = 1'b0;
    bus4.i_gercek_atladi  = 1'b0;
    bus4.i_gercek_hedef   = '0;
  endtask

  task automatic enq1(input logic o, input logic [31:0] pc,
                      input logic [31:0] t);
    bus1.i_ongoru_gecerli = 1'b1;
    bus1.i_ongoru         = o;
    bus1.i_buyruk_sayaci  = pc;
    bus1.i_ongoru_hedef   = t;
  endtask

  task automatic res1(input logic a, input logic [31:0] t);
    bus1.i_cozum_gecerli = 1'b1;
    bus1.i_gercek_atladi = a;
    bus1.i_gercek_hedef  = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bus1.o_hazir !== 1'b1) begin
      $display("FAIL rst_hazir got %0h want 1", bus1.o_hazir);
      failures++;
    end
    checks++;
    if ({bus1.o_guncelle, bus1.o_buyruk_atladi,
         bus1.o_ongoru_yanlis, bus1.o_hata} !== 4'b0) begin
      $display("FAIL rst_flags got %b want 0000",
               {bus1.o_guncelle, bus1.o_buyruk_atladi,
                bus1.o_ongoru_yanlis, bus1.o_hata});
      failures++;
    end
    checks++;
    if ({bus1.o_duzeltme_adresi, bus1.o_dallanma_sayisi,
         bus1.o_yanlis_sayisi} !== 64'd0) begin
      $display("FAIL rst_regs got %h want 0",
               {bus1.o_duzeltme_adresi, bus1.o_dallanma_sayisi,
                bus1.o_yanlis_sayisi});
      failures++;
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_correct();
    enq1(1'b1, 32'h100, 32'h200);
    step();
    clr1();
    res1(1'b1, 32'h200);
    step();
    clr1();
    checks++;
    if ({bus1.o_guncelle, bus1.o_buyruk_atladi,
         bus1.o_ongoru_yanlis} !== 3'b110) begin
      $display("FAIL t1_pulse got %b want 110",
               {bus1.o_guncelle, bus1.o_buyruk_atladi,
                bus1.o_ongoru_yanlis});
      failures++;
    end
    checks++;
    if (bus1.o_dallanma_sayisi !== 16'd1 ||
        bus1.o_yanlis_sayisi !== 16'd0) begin
      $display("FAIL t1_cnt got %0d/%0d want 1/0",
               bus1.o_dallanma_sayisi, bus1.o_yanlis_sayisi);
      failures++;
    end
    step();
    checks++;
    if (bus1.o_guncelle !== 1'b0 || bus1.o_buyruk_atladi !== 1'b1) begin
      $display("FAIL t1_after got %b%b want 01",
               bus1.o_guncelle, bus1.o_buyruk_atladi);
      failures++;
    end
  endtask

  task automatic test_mispredict();
    enq1(1'b0, 32'h40, 32'h0);
    step();
    clr1();
    res1(1'b1, 32'h80);
    step();
    clr1();
    checks++;
    if (bus1.o_ongoru_yanlis !== 1'b1 ||
        bus1.o_duzeltme_adresi !== 32'h80) begin
      $display("FAIL t2_redir got %b %h want 1 80",
               bus1.o_ongoru_yanlis, bus1.o_duzeltme_adresi);
      failures++;
    end
    checks++;
    if (bus1.o_hazir !== 1'b0 || bus1.o_yanlis_sayisi !== 16'd1) begin
      $display("FAIL t2_drain got hazir=%b yanlis=%0d want 0 1",
               bus1.o_hazir, bus1.o_yanlis_sayisi);
      failures++;
    end
    step();
    checks++;
    if (bus1.o_hazir !== 1'b1 || bus1.o_ongoru_yanlis !== 1'b0 ||
        bus1.o_duzeltme_adresi !== 32'h80) begin
      $display("FAIL t2_after got %b %b %h want 1 0 80",
               bus1.o_hazir, bus1.o_ongoru_yanlis,
               bus1.o_duzeltme_adresi);
      failures++;
    end
  endtask

  task automatic test_redirect();
    enq1(1'b1, 32'h10, 32'h30);
    step();
    clr1();
    res1(1'b0, 32'h0);
    step();
    clr1();
    checks++;
    if (bus1.o_ongoru_yanlis !== 1'b1 ||
        bus1.o_duzeltme_adresi !== 32'h14) begin
      $display("FAIL t3_nt got %b %h want 1 14",
               bus1.o_ongoru_yanlis, bus1.o_duzeltme_adresi);
      failures++;
    end
    step();
    enq1(1'b1, 32'h10, 32'h30);
    step();
    clr1();
    res1(1'b1, 32'h34);
    step();
    clr1();
    checks++;
    if (bus1.o_ongoru_yanlis !== 1'b1 ||
        bus1.o_duzeltme_adresi !== 32'h34) begin
      $display("FAIL t3_tgt got %b %h want 1 34",
               bus1.o_ongoru_yanlis, bus1.o_duzeltme_adresi);
      failures++;
    end
    step();
    checks++;
    if (bus1.o_dallanma_sayisi !== 16'd4 ||
        bus1.o_yanlis_sayisi !== 16'd3) begin
      $display("FAIL t3_cnt got %0d/%0d want 4/3",
               bus1.o_dallanma_sayisi, bus1.o_yanlis_sayisi);
      failures++;
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      enq1(~i[0], 32'h1000 + 32'(i) * 16, 32'h2000 + 32'(i) * 16);
      step();
    end
    checks++;
    if (bus1.o_hazir !== 1'b0) begin
      $display("FAIL t4_full got %b want 0", bus1.o_hazir);
      failures++;
    end
    enq1(1'b1, 32'h1040, 32'h2040);
    step();
    clr1();
    checks++;
    if (bus1.o_hata !== 1'b1) begin
      $display("FAIL t4_hata got %b want 1", bus1.o_hata);
      failures++;
    end
    for (int i = 0; i < 4; i++) begin
      res1(~i[0], 32'h2000 + 32'(i) * 16);
      step();
      checks++;
      if (bus1.o_guncelle !== 1'b1 || bus1.o_ongoru_yanlis !== 1'b0 ||
          bus1.o_buyruk_atladi !== ~i[0]) begin
        $display("FAIL t4_res%0d got %b%b%b want 10%b", i,
                 bus1.o_guncelle, bus1.o_ongoru_yanlis,
                 bus1.o_buyruk_atladi, ~i[0]);
        failures++;
      end
    end
    clr1();
    step();
    checks++;
    if (bus1.o_hazir !== 1'b1 || bus1.o_guncelle !== 1'b0 ||
        bus1.o_dallanma_sayisi !== 16'd8) begin
      $display("FAIL t4_end got %b %b %0d want 1 0 8",
               bus1.o_hazir, bus1.o_guncelle, bus1.o_dallanma_sayisi);
      failures++;
    end
  endtask

  task automatic test_flush();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    enq1(1'b0, 32'h500, 32'h600);
    step();
    enq1(1'b1, 32'h510, 32'h700);
    step();
    enq1(1'b1, 32'h520, 32'h800);
    step();
    enq1(1'b1, 32'h530, 32'h900);
    res1(1'b1, 32'h900);
    step();
    clr1();
    checks++;
    if (bus1.o_ongoru_yanlis !== 1'b1 ||
        bus1.o_duzeltme_adresi !== 32'h900 || bus1.o_hazir !== 1'b0) begin
      $display("FAIL t5_mis got %b %h %b want 1 900 0",
               bus1.o_ongoru_yanlis, bus1.o_duzeltme_adresi,
               bus1.o_hazir);
      failures++;
    end
    enq1(1'b1, 32'h540, 32'h0);
    res1(1'b1, 32'h0);
    step();
    clr1();
    checks++;
    if (bus1.o_guncelle !== 1'b0 || bus1.o_hata !== 1'b0 ||
        bus1.o_ongoru_yanlis !== 1'b0 || bus1.o_hazir !== 1'b1) begin
      $display("FAIL t5_drain got %b%b%b%b want 0001",
               bus1.o_guncelle, bus1.o_hata,
               bus1.o_ongoru_yanlis, bus1.o_hazir);
      failures++;
    end
    res1(1'b0, 32'h0);
    step();
    clr1();
    checks++;
    if (bus1.o_hata !== 1'b1 || bus1.o_guncelle !== 1'b0) begin
      $display("FAIL t5_empty got hata=%b upd=%b want 1 0",
               bus1.o_hata, bus1.o_guncelle);
      failures++;
    end
    step();
    checks++;
    if (bus1.o_yanlis_sayisi !== 16'd1 ||
        bus1.o_dallanma_sayisi !== 16'd1) begin
      $display("FAIL t5_cnt got %0d/%0d want 1/1",
               bus1.o_dallanma_sayisi, bus1.o_yanlis_sayisi);
      failures++;
    end
  endtask

  task automatic test_saturate();
    rst4 = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      bus4.i_ongoru_gecerli = 1'b1;
      bus4.i_ongoru         = 1'b0;
      bus4.i_buyruk_sayaci  = 32'h3000 + 32'(i) * 4;
      step();
      clr4();
      bus4.i_cozum_gecerli = 1'b1;
      bus4.i_gercek_atladi = 1'b1;
      bus4.i_gercek_hedef  = 32'h4000;
      step();
      clr4();
      step();
    end
    checks++;
    if (bus4.o_dallanma_sayisi !== 4'd15 ||
        bus4.o_yanlis_sayisi !== 4'd15) begin
      $display("FAIL t6_sat got %0d/%0d want 15/15",
               bus4.o_dallanma_sayisi, bus4.o_yanlis_sayisi);
      failures++;
    end
    bus4.i_ongoru_gecerli = 1'b1;
    bus4.i_ongoru         = 1'b0;
    bus4.i_buyruk_sayaci  = 32'h5000;
    step();
    clr4();
    bus4.i_cozum_gecerli = 1'b1;
    bus4.i_gercek_atladi = 1'b1;
    bus4.i_gercek_hedef  = 32'h6000;
    step();
    clr4();
    checks++;
    if (bus4.o_guncelle !== 1'b1 || bus4.o_ongoru_yanlis !== 1'b1) begin
      $display("FAIL t6_pre got %b%b want 11",
               bus4.o_guncelle, bus4.o_ongoru_yanlis);
      failures++;
    end
    #2;
    rst4 = 1'b1;
    #1;
    checks++;
    if ({bus4.o_guncelle, bus4.o_buyruk_atladi, bus4.o_ongoru_yanlis,
         bus4.o_hata, bus4.o_hazir} !== 5'b00001) begin
      $display("FAIL t6_rst_flags got %b want 00001",
               {bus4.o_guncelle, bus4.o_buyruk_atladi,
                bus4.o_ongoru_yanlis, bus4.o_hata, bus4.o_hazir});
      failures++;
    end
    checks++;
    if (bus4.o_duzeltme_adresi !== 32'd0 ||
        bus4.o_dallanma_sayisi !== 4'd0 ||
        bus4.o_yanlis_sayisi !== 4'd0) begin
      $display("FAIL t6_rst_regs got %h %0d %0d want 0 0 0",
               bus4.o_duzeltme_adresi, bus4.o_dallanma_sayisi,
               bus4.o_yanlis_sayisi);
      failures++;
    end
  endtask

  initial begin
    clr1();
    clr4();
    test_reset();
    test_correct();
    test_mispredict();
    test_redirect();
    test_full();
    test_flush();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
